// File: rtl/vga_fetch_ctrl.sv
// vga_fetch_ctrl
//   Frame-buffer fetch controller for the VGA output stage. Issues burst reads
//   to the SDRAM arbiter to keep an internal word FIFO topped up, and presents
//   the head pixel of that FIFO as 24-bit grey RGB. The downstream stage pops
//   one pixel per new_pixel pulse and restarts the frame with new_frame.
//
//   Ports
//     clock, reset          system clock, synchronous active-high reset
//     new_frame             pulse: flush FIFO, restart fetching at FB_BASE
//     new_pixel             pulse: consume the current head pixel
//     pixel_data[23:0]      registered head pixel {g,g,g}, 0 when FIFO empty
//     mem_req, mem_addr     burst read request and its byte address
//     mem_ack               arbiter accepted the pending request
//     mem_rvalid, mem_rdata returned read words (byte 0 = leftmost pixel)
//     underflow             sticky: a pop arrived while the FIFO was empty
//
//   Fetching does not start after reset until the first new_frame arms it;
//   the output stage always frames the display with new_frame first.
module vga_fetch_ctrl #(
    parameter logic [25:0] FB_BASE     = 26'h3f80000,
    parameter int          FB_BYTES    = 307200,
    parameter int          BURST_WORDS = 8,
    parameter int          FIFO_WORDS  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        new_frame,
    input  logic        new_pixel,
    output logic [23:0] pixel_data,
    output logic        mem_req,
    output logic [25:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        underflow
);
    localparam int AW  = $clog2(FIFO_WORDS);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(BURST_WORDS) + 1;

    localparam logic [25:0]    FB_END      = FB_BASE + 26'(FB_BYTES);
    localparam logic [25:0]    BURST_BYTES = 26'(BURST_WORDS * 4);
    localparam logic [CW-1:0]  FILL_LIMIT  = CW'(FIFO_WORDS - BURST_WORDS);
    localparam logic [CW-1:0]  FULL_COUNT  = CW'(FIFO_WORDS);
    localparam logic [BCW-1:0] LAST_BEAT   = BCW'(BURST_WORDS - 1);
    localparam logic [BCW-1:0] BURST_CNT   = BCW'(BURST_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            armed_q, armed_d;
    logic [25:0]     fetch_ptr_q, fetch_ptr_d;
    logic [25:0]     mem_addr_q, mem_addr_d;
    logic            mem_req_q, mem_req_d;
    logic [BCW-1:0]  beat_q, beat_d;
    logic [BCW-1:0]  discard_q, discard_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [1:0]      bsel_q, bsel_d;
    logic [7:0]      pix_q, pix_d;
    logic            underflow_q, underflow_d;

    logic [31:0]     fifo_mem [FIFO_WORDS];
    logic            fifo_we;
    logic            pop;
    logic            word_free;
    logic [31:0]     head_word;
    logic [BCW-1:0]  drain_rem;

    // ------------------------------------------------------------------
    // FIFO bookkeeping and pixel path
    // ------------------------------------------------------------------
    always_comb begin
        // A flush on new_frame overrides both the pop and any returning beat.
        pop         = new_pixel && !new_frame;
        fifo_we     = (state_q == DATA) && mem_rvalid && !new_frame;
        word_free   = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        bsel_d      = bsel_q;
        underflow_d = underflow_q;

        if (new_frame) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            bsel_d      = '0;
            underflow_d = 1'b0;
        end else begin
            if (pop) begin
                if (count_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    bsel_d = bsel_q + 2'd1;
                    if (bsel_q == 2'd3) begin
                        word_free = 1'b1;
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                    end
                end
            end
            if (fifo_we) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(fifo_we) - CW'(word_free);
        end

        // The new head may be the word being written this very cycle (write
        // into an empty FIFO, or the last word freed while the next arrives);
        // it is not in the array yet, so take it straight from the bus.
        if (fifo_we && (rd_ptr_d == wr_ptr_q)) begin
            head_word = mem_rdata;
        end else begin
            head_word = fifo_mem[rd_ptr_d];
        end
        pix_d = (count_d == '0) ? 8'h00 : head_word[{bsel_d, 3'b000} +: 8];
    end

    always_ff @(posedge clock) begin
        if (fifo_we) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Burst fetch FSM (at most one burst outstanding)
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | new_frame;
        fetch_ptr_d = fetch_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        beat_d      = beat_q;
        discard_d   = discard_q;
        // Beats of the current burst still to come if it is abandoned now.
        drain_rem   = BURST_CNT - beat_q - BCW'(mem_rvalid);

        if (new_frame) begin
            fetch_ptr_d = FB_BASE;
        end

        case (state_q)
            IDLE: begin
                // Only IDLE issues requests and nothing is in flight here, so
                // comparing the occupancy against the fill limit reserves room
                // for the whole burst before it is requested.
                if (!new_frame && armed_q && (fetch_ptr_q < FB_END) &&
                    (count_q <= FILL_LIMIT)) begin
                    state_d    = REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_ptr_q;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (new_frame) begin
                        // The accepted burst belongs to the old frame.
                        state_d   = DRAIN;
                        discard_d = BURST_CNT;
                    end else begin
                        fetch_ptr_d = fetch_ptr_q + BURST_BYTES;
                        beat_d      = '0;
                        state_d     = DATA;
                    end
                end else if (new_frame) begin
                    // The arbiter samples the address only on ack, so the
                    // pending request can simply be retargeted.
                    mem_addr_d = FB_BASE;
                end
            end
            DATA: begin
                if (new_frame) begin
                    if (drain_rem == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DRAIN;
                        discard_d = drain_rem;
                    end
                end else if (mem_rvalid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    if (discard_q == BCW'(1)) begin
                        discard_d = '0;
                        state_d   = IDLE;
                    end else begin
                        discard_d = discard_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            fetch_ptr_q <= FB_BASE;
            mem_addr_q  <= FB_BASE;
            mem_req_q   <= 1'b0;
            beat_q      <= '0;
            discard_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bsel_q      <= '0;
            pix_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            fetch_ptr_q <= fetch_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            beat_q      <= beat_d;
            discard_q   <= discard_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            bsel_q      <= bsel_d;
            pix_q       <= pix_d;
            underflow_q <= underflow_d;
        end
    end

    // A write into a full FIFO means the free-space reservation is broken.
    fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(fifo_we && (count_q == FULL_COUNT)));

    // ------------------------------------------------------------------
    // Outputs: grey byte replicated onto the three colour channels
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rgb
            assign pixel_data[gi*8 +: 8] = pix_q;
        end
    endgenerate

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// tb_vga_fetch_ctrl
//   Bench for vga_fetch_ctrl with a shortened frame (1024 bytes) so a whole
//   frame can be streamed. A behavioural arbiter/SDRAM model acks requests
//   after a programmable delay and returns a deterministic byte pattern
//   (byte at frame offset o = (o+1)*17 mod 256, so the first word is
//   0x44332211). Expected head pixels are queued and compared at each pop.
module tb_vga_fetch_ctrl;
    localparam logic [25:0] FB_BASE = 26'h3f80000;
    localparam int          FRAME   = 1024;

    logic        clock;
    logic        reset;
    logic        new_frame;
    logic        new_pixel;
    logic [23:0] pixel_data;
    logic        mem_req;
    logic [25:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        underflow;

    vga_fetch_ctrl #(
        .FB_BASE    (FB_BASE),
        .FB_BYTES   (FRAME),
        .BURST_WORDS(8),
        .FIFO_WORDS (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .new_frame (new_frame),
        .new_pixel (new_pixel),
        .pixel_data(pixel_data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #4 clock = ~clock;

    typedef struct {
        logic [23:0] exp_pix;
        logic        exp_uf;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_dly = 3;
    int          pause_at = -1;
    bit          pause_release = 1'b0;
    bit          paused = 1'b0;
    int          burst_cnt = 0;
    logic [25:0] addr_log [$];
    logic [23:0] exp_q [$];

    function automatic logic [7:0] pb(input int o);
        return 8'((o + 1) * 17);
    endfunction

    function automatic logic [31:0] word_at(input logic [25:0] a);
        int o;
        o = int'(a - FB_BASE);
        return {pb(o + 3), pb(o + 2), pb(o + 1), pb(o)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Samples the head pixel mid-cycle, compares it with the next scoreboard
    // entry, then issues the pop; pops are 4 cycles apart.
    task automatic pop_check(input string nm);
        logic [23:0] e;
        @(negedge clock);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %h expected <none queued>", nm, pixel_data);
        end else begin
            e = exp_q.pop_front();
            chk(nm, 32'(pixel_data), 32'(e));
        end
        new_pixel = 1'b1;
        @(negedge clock);
        new_pixel = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic frame_pulse(input bit clr);
        @(negedge clock);
        if (clr) begin
            burst_cnt = 0;
            addr_log.delete();
        end
        new_frame = 1'b1;
        @(negedge clock);
        new_frame = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 30; i++) begin
            @(negedge clock);
            quiet = (mem_req || mem_rvalid) ? 0 : quiet + 1;
        end
        chk(nm, 32'(quiet >= 30), 32'd1);
    endtask

    // Arbiter + SDRAM model: ack after ack_dly cycles of pending request,
    // then eight consecutive beats, optionally stalling before beat pause_at.
    initial begin : mem_model
        int          waitc;
        logic [25:0] baddr;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        waitc      = 0;
        forever begin
            @(negedge clock);
            if (!reset && mem_req) begin
                waitc++;
                if (waitc >= ack_dly) begin
                    mem_ack = 1'b1;
                    baddr   = mem_addr;
                    burst_cnt++;
                    addr_log.push_back(baddr);
                    @(negedge clock);
                    mem_ack = 1'b0;
                    waitc   = 0;
                    for (int b = 0; b < 8; b++) begin
                        if (b == pause_at) begin
                            paused = 1'b1;
                            while (!pause_release) @(negedge clock);
                            paused = 1'b0;
                        end
                        mem_rvalid = 1'b1;
                        mem_rdata  = word_at(baddr + 26'(b * 4));
                        @(negedge clock);
                        mem_rvalid = 1'b0;
                    end
                end
            end else begin
                waitc = 0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        vec_t tbl [8];
        bit   seen;
        int   k;

        tbl[0] = '{24'h111111, 1'b0};
        tbl[1] = '{24'h222222, 1'b0};
        tbl[2] = '{24'h333333, 1'b0};
        tbl[3] = '{24'h444444, 1'b0};
        tbl[4] = '{24'h555555, 1'b0};
        tbl[5] = '{24'h666666, 1'b0};
        tbl[6] = '{24'h777777, 1'b0};
        tbl[7] = '{24'h888888, 1'b0};

        reset     = 1'b1;
        new_frame = 1'b0;
        new_pixel = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;

        // Reset state, no fetching before the first new_frame.
        seen = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (mem_req) seen = 1'b1;
        end
        chk("t1_no_req", 32'(seen), 32'd0);
        chk("t1_pixel", 32'(pixel_data), 32'd0);
        chk("t1_underflow", 32'(underflow), 32'd0);
        chk("t1_mem_addr", 32'(mem_addr), 32'(FB_BASE));

        // First frame: addresses and byte order of the first word.
        frame_pulse(1'b1);
        repeat (40) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tbl[i].exp_pix);
            pop_check("t2_pop");
            chk("t2_underflow", 32'(underflow), 32'(tbl[i].exp_uf));
        end
        chk("t2_two_bursts", 32'(addr_log.size() >= 2), 32'd1);
        if (addr_log.size() >= 2) begin
            chk("t2_addr0", 32'(addr_log[0]), 32'h3f80000);
            chk("t2_addr1", 32'(addr_log[1]), 32'h3f80020);
        end

        // Fill to full without pops, then free-space threshold.
        wait_quiet("t3_quiet");
        frame_pulse(1'b1);
        repeat (300) @(negedge clock);
        chk("t3_bursts_full", 32'(burst_cnt), 32'd8);
        chk("t3_req_idle", 32'(mem_req), 32'd0);
        if (addr_log.size() > 0) chk("t3_last_addr", 32'(addr_log[$]), 32'h3f800e0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({3{pb(i)}});
            pop_check("t3_pop");
        end
        repeat (50) @(negedge clock);
        chk("t3_no_req_after_8", 32'(burst_cnt), 32'd8);
        chk("t3_req_low_after_8", 32'(mem_req), 32'd0);
        ack_dly = 12;
        for (int i = 8; i < 32; i++) begin
            exp_q.push_back({3{pb(i)}});
            pop_check("t3_pop");
        end
        k = 0;
        while (!mem_req && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("t3_req_after_32", 32'(mem_req), 32'd1);
        chk("t3_req_addr", 32'(mem_addr), 32'h3f80100);
        chk("t3_bursts_pending", 32'(burst_cnt), 32'd8);
        // new_frame while the request waits for ack: retarget to the base.
        frame_pulse(1'b0);
        chk("t3_retarget_req", 32'(mem_req), 32'd1);
        chk("t3_retarget_addr", 32'(mem_addr), 32'(FB_BASE));
        repeat (20) @(negedge clock);
        chk("t3_bursts_retarget", 32'(burst_cnt), 32'd9);
        if (addr_log.size() > 0) chk("t3_ack_addr", 32'(addr_log[$]), 32'(FB_BASE));
        chk("t3_head_after_flush", 32'(pixel_data), 32'h111111);
        ack_dly = 3;

        // new_frame with the burst stalled before beat 3.
        wait_quiet("t4_quiet");
        pause_at      = 3;
        pause_release = 1'b0;
        frame_pulse(1'b1);
        k = 0;
        while (!paused && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("t4_paused", 32'(paused), 32'd1);
        frame_pulse(1'b1);
        pause_at      = -1;
        pause_release = 1'b1;
        @(negedge clock);
        chk("t4_flushed_pixel", 32'(pixel_data), 32'd0);
        repeat (60) @(negedge clock);
        pause_release = 1'b0;
        chk("t4_rebursts", 32'(addr_log.size() >= 1), 32'd1);
        if (addr_log.size() > 0) chk("t4_addr", 32'(addr_log[0]), 32'(FB_BASE));
        exp_q.push_back(24'h111111);
        pop_check("t4_pop");
        exp_q.push_back(24'h222222);
        pop_check("t4_pop");
        chk("t4_underflow", 32'(underflow), 32'd0);

        // Whole (shortened) frame streamed at one pop per 4 clocks.
        wait_quiet("t5_quiet");
        frame_pulse(1'b1);
        repeat (30) @(negedge clock);
        for (int i = 0; i < FRAME; i++) exp_q.push_back({3{pb(i)}});
        for (int i = 0; i < FRAME; i++) pop_check("t5_pop");
        repeat (60) @(negedge clock);
        chk("t5_bursts", 32'(burst_cnt), 32'(FRAME / 32));
        if (addr_log.size() > 0) chk("t5_last_addr", 32'(addr_log[$]), 32'(FB_BASE) + 32'(FRAME - 32));
        chk("t5_underflow", 32'(underflow), 32'd0);
        chk("t5_req_idle", 32'(mem_req), 32'd0);
        chk("t5_empty_pixel", 32'(pixel_data), 32'd0);

        // Pop on an empty FIFO, then clear by new_frame.
        @(negedge clock);
        new_pixel = 1'b1;
        @(negedge clock);
        new_pixel = 1'b0;
        @(negedge clock);
        chk("t6_underflow_set", 32'(underflow), 32'd1);
        chk("t6_pixel_zero", 32'(pixel_data), 32'd0);
        frame_pulse(1'b1);
        chk("t6_underflow_clr", 32'(underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
